// File: rtl/dmac_fifo_requester_if.sv
// Handshake bundle between the DMAC FIFO requester and the FIFO it drives.
// The requester uses the master view; the FIFO uses the slave view.
interface dmac_fifo_requester_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_wr_ack;
    logic                  fifo_wr_err;
    logic                  fifo_rd_ack;
    logic                  fifo_rd_err;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_wr_en;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_din;

    modport master (
        input  fifo_full, fifo_empty, fifo_wr_ack, fifo_wr_err,
               fifo_rd_ack, fifo_rd_err, fifo_dout,
        output fifo_wr_en, fifo_rd_en, fifo_din
    );

    modport slave (
        output fifo_full, fifo_empty, fifo_wr_ack, fifo_wr_err,
               fifo_rd_ack, fifo_rd_err, fifo_dout,
        input  fifo_wr_en, fifo_rd_en, fifo_din
    );
endinterface

// File: rtl/dmac_fifo_requester.sv
// Moves len words into or out of the DMAC FIFO one request at a time,
// retrying refused requests and reporting done or abort.
module dmac_fifo_requester #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_RETRY  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  dir,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_pop,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic                  dst_valid,
    output logic                  busy,
    output logic [LEN_WIDTH-1:0]  xfer_cnt,
    output logic                  done,
    output logic                  abort,
    output logic [3:0]            retry_cnt,
    dmac_fifo_requester_if.master fifo
);
    localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t                state;
    logic                  dir_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  issue_ok;
    logic                  ack;
    logic                  err;
    logic                  accepted;
    logic [LEN_WIDTH-1:0]  xfer_nxt;
    logic [3:0]            retry_nxt;

    // Request and pop are decoded from the registered state so a request and
    // its response fit in two cycles, and the source can advance right at the
    // edge that consumes the acknowledged word.
    assign issue_ok        = (state == S_ISSUE) && (dir_q ? !fifo.fifo_empty : !fifo.fifo_full);
    assign fifo.fifo_wr_en = issue_ok && !dir_q;
    assign fifo.fifo_rd_en = issue_ok && dir_q;
    assign fifo.fifo_din   = fifo.fifo_wr_en ? src_data : '0;

    assign ack       = dir_q ? fifo.fifo_rd_ack : fifo.fifo_wr_ack;
    assign err       = dir_q ? fifo.fifo_rd_err : fifo.fifo_wr_err;
    // Contradictory ack+err, or silence, is a refused request.
    assign accepted  = ack && !err;
    assign xfer_nxt  = xfer_cnt + 1'b1;
    assign retry_nxt = retry_cnt + 4'd1;

    assign src_pop = (state == S_WAIT) && !dir_q && accepted;
    assign busy    = (state == S_ISSUE) || (state == S_WAIT);
    assign done    = (state == S_DONE);
    assign abort   = (state == S_ABORT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            dir_q     <= 1'b0;
            len_q     <= '0;
            xfer_cnt  <= '0;
            retry_cnt <= '0;
            dst_data  <= '0;
            dst_valid <= 1'b0;
        end else begin
            dst_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dir_q     <= dir;
                        len_q     <= len;
                        xfer_cnt  <= '0;
                        retry_cnt <= '0;
                        state     <= (len == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_ok) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (accepted) begin
                        xfer_cnt  <= xfer_nxt;
                        retry_cnt <= '0;
                        if (dir_q) begin
                            dst_data  <= fifo.fifo_dout;
                            dst_valid <= 1'b1;
                        end
                        state <= (xfer_nxt == len_q) ? S_DONE : S_ISSUE;
                    end else begin
                        retry_cnt <= retry_nxt;
                        state     <= (retry_nxt == RETRY_LIM) ? S_ABORT : S_ISSUE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ABORT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmac_fifo_requester.sv
// Scoreboard bench for dmac_fifo_requester: stimulus posts expected events
// and probes, a negedge monitor compares them against the DUT.
module tb_dmac_fifo_requester;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int MR = 4;

    localparam logic [DW-1:0] WA = 32'hA0A0_0001;
    localparam logic [DW-1:0] WB = 32'hB0B0_0002;
    localparam logic [DW-1:0] WC = 32'hC0C0_0003;

    // probe codes
    localparam int P_BUSY = 0, P_XFER = 1, P_RETRY = 2, P_WREN = 3, P_RDEN = 4,
                   P_DONE = 5, P_ABORT = 6, P_DVAL = 7, P_POP = 8, P_DDATA = 9,
                   P_DIN = 10;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          dir;
    logic [LW-1:0] len;
    logic [DW-1:0] src_data;
    logic          src_pop;
    logic [DW-1:0] dst_data;
    logic          dst_valid;
    logic          busy;
    logic [LW-1:0] xfer_cnt;
    logic          done;
    logic          abort;
    logic [3:0]    retry_cnt;

    dmac_fifo_requester_if #(.DATA_WIDTH(DW)) fif();

    dmac_fifo_requester #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dir(dir), .len(len),
        .src_data(src_data), .src_pop(src_pop), .dst_data(dst_data),
        .dst_valid(dst_valid), .busy(busy), .xfer_cnt(xfer_cnt), .done(done),
        .abort(abort), .retry_cnt(retry_cnt), .fifo(fif.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO and source model
    logic          err_mode;
    logic          full_in;
    logic          clr;
    logic [2:0]    rd_n;
    logic [1:0]    rd_ptr = '0;
    logic [2:0]    src_idx = '0;
    logic [DW-1:0] src_words [0:7];
    logic [DW-1:0] rd_words [0:3];

    assign src_data       = src_words[src_idx];
    assign fif.fifo_full  = full_in;
    assign fif.fifo_empty = ({1'b0, rd_ptr} >= rd_n);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fif.fifo_wr_ack <= 1'b0;
            fif.fifo_wr_err <= 1'b0;
            fif.fifo_rd_ack <= 1'b0;
            fif.fifo_rd_err <= 1'b0;
            fif.fifo_dout   <= '0;
        end else begin
            fif.fifo_wr_ack <= fif.fifo_wr_en && !err_mode;
            fif.fifo_wr_err <= fif.fifo_wr_en && err_mode;
            fif.fifo_rd_ack <= fif.fifo_rd_en;
            fif.fifo_rd_err <= 1'b0;
            if (fif.fifo_rd_en) fif.fifo_dout <= rd_words[rd_ptr];
            if (clr) begin
                src_idx <= '0;
                rd_ptr  <= '0;
            end else begin
                if (src_pop) src_idx <= src_idx + 3'd1;
                if (fif.fifo_rd_en) rd_ptr <= rd_ptr + 2'd1;
            end
        end
    end

    // scoreboard
    ev_t wr_q[$], rd_q[$], dst_q[$], end_q[$], probe_q[$];
    int  n_pass = 0;
    int  n_tot  = 0;
    logic fin = 1'b0;
    logic mon_done = 1'b0;
    int  t0;

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, a, e);
    endfunction

    function automatic logic [31:0] probe_val(int code);
        case (code)
            P_BUSY:  return 32'(busy);
            P_XFER:  return 32'(xfer_cnt);
            P_RETRY: return 32'(retry_cnt);
            P_WREN:  return 32'(fif.fifo_wr_en);
            P_RDEN:  return 32'(fif.fifo_rd_en);
            P_DONE:  return 32'(done);
            P_ABORT: return 32'(abort);
            P_DVAL:  return 32'(dst_valid);
            P_POP:   return 32'(src_pop);
            P_DDATA: return dst_data;
            default: return fif.fifo_din;
        endcase
    endfunction

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (fif.fifo_wr_en === 1'b1) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_cyc", cyc, e.cyc);
                    chk("wr_din", fif.fifo_din, e.val);
                end
            end
            if (fif.fifo_rd_en === 1'b1) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cyc", cyc, e.cyc);
                end
            end
            if (dst_valid === 1'b1) begin
                if (dst_q.size() == 0) chk("dst_unexpected", 1, 0);
                else begin
                    e = dst_q.pop_front();
                    chk("dst_cyc", cyc, e.cyc);
                    chk("dst_data", dst_data, e.val);
                end
            end
            if (done === 1'b1 || abort === 1'b1) begin
                if (end_q.size() == 0) chk("end_unexpected", 1, 0);
                else begin
                    e = end_q.pop_front();
                    chk("end_cyc", cyc, e.cyc);
                    chk("end_kind", done ? 1 : 2, e.kind);
                    chk("end_xfer_cnt", 32'(xfer_cnt), e.val);
                end
            end
            for (int i = probe_q.size() - 1; i >= 0; i--) begin
                if (probe_q[i].cyc == cyc) begin
                    chk($sformatf("probe%0d", probe_q[i].kind), probe_val(probe_q[i].kind), probe_q[i].val);
                    probe_q.delete(i);
                end else if (probe_q[i].cyc < cyc) begin
                    chk("probe_late", cyc, probe_q[i].cyc);
                    probe_q.delete(i);
                end
            end
            if (fin && !mon_done) begin
                chk("left_wr", wr_q.size(), 0);
                chk("left_rd", rd_q.size(), 0);
                chk("left_dst", dst_q.size(), 0);
                chk("left_end", end_q.size(), 0);
                chk("left_probe", probe_q.size(), 0);
                mon_done = 1'b1;
            end
        end
    end

    // stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        t0 = cyc;
    endtask

    task automatic ex_wr(int k, logic [31:0] v); wr_q.push_back('{t0 + k, 0, v}); endtask
    task automatic ex_rd(int k); rd_q.push_back('{t0 + k, 0, 0}); endtask
    task automatic ex_dst(int k, logic [31:0] v); dst_q.push_back('{t0 + k, 0, v}); endtask
    task automatic ex_end(int k, int kind, logic [31:0] v); end_q.push_back('{t0 + k, kind, v}); endtask
    task automatic probe(int k, int code, logic [31:0] v); probe_q.push_back('{t0 + k, code, v}); endtask

    task automatic kick(logic d, int n);
        dir   = d;
        len   = LW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_model();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b1;
        start    = 1'b0;
        dir      = 1'b0;
        len      = '0;
        err_mode = 1'b0;
        full_in  = 1'b0;
        clr      = 1'b0;
        rd_n     = 3'd0;
        src_words[0] = WA; src_words[1] = WB; src_words[2] = WC;
        for (int i = 3; i < 8; i++) src_words[i] = 32'hDEAD_0000 + 32'(i);
        rd_words[0] = 32'h11; rd_words[1] = 32'h22; rd_words[2] = 32'h33; rd_words[3] = 32'h44;
        #1 reset_n = 1'b0;

        // reset state
        arm();
        for (int c = 0; c <= P_DIN; c++) probe(1, c, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        clear_model();

        // write len=3, always acked
        arm();
        ex_wr(1, WA); ex_wr(3, WB); ex_wr(5, WC);
        ex_end(7, 1, 3);
        probe(1, P_BUSY, 1); probe(2, P_POP, 1); probe(3, P_POP, 0);
        probe(4, P_POP, 1); probe(6, P_POP, 1); probe(7, P_BUSY, 0);
        probe(8, P_XFER, 3);
        kick(1'b0, 3);
        repeat (9) tick();
        clear_model();

        // read len=2, FIFO holds 0x11, 0x22
        rd_n = 3'd2;
        arm();
        ex_rd(1); ex_rd(3);
        ex_dst(3, 32'h11); ex_dst(5, 32'h22);
        ex_end(5, 1, 2);
        probe(6, P_XFER, 2); probe(6, P_DDATA, 32'h22);
        kick(1'b1, 2);
        repeat (8) tick();
        rd_n = 3'd0;
        clear_model();

        // write stalled by full for 5 cycles
        full_in = 1'b1;
        arm();
        for (int k = 1; k <= 5; k++) begin
            probe(k, P_WREN, 0); probe(k, P_RETRY, 0); probe(k, P_BUSY, 1);
        end
        ex_wr(6, WA);
        ex_end(8, 1, 1);
        kick(1'b0, 1);
        repeat (5) tick();
        full_in = 1'b0;
        repeat (5) tick();
        clear_model();

        // write len=4, every response is wr_err
        err_mode = 1'b1;
        arm();
        ex_wr(1, WA); ex_wr(3, WA); ex_wr(5, WA); ex_wr(7, WA);
        ex_end(9, 2, 0);
        probe(2, P_RETRY, 0); probe(3, P_RETRY, 1); probe(5, P_RETRY, 2);
        probe(7, P_RETRY, 3); probe(2, P_POP, 0); probe(8, P_POP, 0);
        probe(9, P_BUSY, 0); probe(9, P_DONE, 0);
        kick(1'b0, 4);
        repeat (11) tick();
        err_mode = 1'b0;
        clear_model();

        // len=0 finishes without a request
        arm();
        ex_end(1, 1, 0);
        probe(1, P_BUSY, 0);
        kick(1'b0, 0);
        repeat (4) tick();
        clear_model();

        // start while busy is ignored
        arm();
        ex_wr(1, WA);
        ex_end(3, 1, 1);
        dir = 1'b0; len = LW'(1); start = 1'b1;
        tick();
        len = LW'(3);
        tick();
        start = 1'b0;
        repeat (6) tick();
        clear_model();

        // reset during WAIT of a len=5 write
        arm();
        ex_wr(1, WA); ex_wr(3, WB);
        probe(3, P_XFER, 1);
        probe(4, P_BUSY, 0); probe(4, P_XFER, 0); probe(4, P_RETRY, 0);
        probe(4, P_WREN, 0); probe(4, P_DONE, 0); probe(4, P_ABORT, 0);
        probe(4, P_POP, 0); probe(4, P_DIN, 0);
        kick(1'b0, 5);
        repeat (3) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        clear_model();

        arm();
        ex_wr(1, WA);
        ex_end(3, 1, 1);
        kick(1'b0, 1);
        repeat (5) tick();

        fin = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) tick();
        if (!mon_done) begin
            $display("FAIL monitor_final: got no final check, required one within 10 cycles");
            $fatal(1);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
